// File: rtl/itr_ctrl.sv
// Interrupt sequencer for the core's single itr input, IO-bus mapped.
// Define ITR_CTRL_EDGE_EN for edge-latched sources; default is level mode.
module itr_ctrl #(
    parameter int NSRC      = 4,
    parameter int NUBITS    = 32,
    parameter int NADDR     = 3,
    parameter int MASK_ADDR = 0,
    parameter int ACK_ADDR  = 1,
    parameter int VEC_ADDR  = 0,
    parameter int STAT_ADDR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   src,
    input  logic              out_en,
    input  logic [NADDR-1:0]  addr_out,
    input  logic [NUBITS-1:0] data_out,
    input  logic              req_in,
    input  logic [NADDR-1:0]  addr_in,
    output logic [NUBITS-1:0] io_data,
    output logic              io_sel,
    output logic              itr
);

    localparam int VW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        SERVICE
    } state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] src_m_q, src_s_q;
    logic [NSRC-1:0] pending, active;
    logic [7:0]      lost;
    logic            wr_mask, wr_ack;
    logic            unused_bits;

    assign wr_mask     = out_en && (addr_out == NADDR'(MASK_ADDR));
    assign wr_ack      = out_en && (addr_out == NADDR'(ACK_ADDR));
    assign unused_bits = ^data_out[NUBITS-1:NSRC];

    always_comb begin
        mask_d = mask_q;
        if (wr_mask) begin
            mask_d = data_out[NSRC-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        itr     = 1'b0;
        active  = pending & mask_q;
        unique case (state_q)
            IDLE: begin
                if (|active) begin
                    state_d = FIRE;
                    // Scan downward so the lowest index wins
                    for (int i = NSRC - 1; i >= 0; i--) begin
                        if (active[i]) begin
                            vec_d = VW'(i);
                        end
                    end
                end
            end
            FIRE: begin
                itr     = 1'b1;
                state_d = SERVICE;
            end
            SERVICE: begin
                if (wr_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            mask_q  <= '0;
            src_m_q <= '0;
            src_s_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            mask_q  <= mask_d;
            src_m_q <= src;
            src_s_q <= src_m_q;
        end
    end

`ifdef ITR_CTRL_EDGE_EN
    logic [NSRC-1:0] src_d_q;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] rise, hit, ack_clr;
    logic [7:0]      lost_q, lost_d;
    logic [3:0]      n_hit;
    logic [8:0]      lost_sum;
    logic            wr_stat;

    assign wr_stat = out_en && (addr_out == NADDR'(STAT_ADDR));

    always_comb begin
        ack_clr = '0;
        if (state_q == SERVICE && wr_ack) begin
            ack_clr = NSRC'(1) << vec_q;
        end
        rise      = src_s_q & ~src_d_q;
        // A fresh edge on the bit being acknowledged is a new request
        hit       = rise & pending_q & ~ack_clr;
        pending_d = (pending_q & ~ack_clr) | rise;
        n_hit     = '0;
        for (int i = 0; i < NSRC; i++) begin
            n_hit = n_hit + 4'(hit[i]);
        end
        lost_sum = {1'b0, lost_q} + 9'(n_hit);
        lost_d   = lost_sum[8] ? 8'hff : lost_sum[7:0];
        if (wr_stat) begin
            lost_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_d_q   <= '0;
            pending_q <= '0;
            lost_q    <= '0;
        end else begin
            src_d_q   <= src_s_q;
            pending_q <= pending_d;
            lost_q    <= lost_d;
        end
    end

    assign pending = pending_q;
    assign lost    = lost_q;
`else
    assign pending = src_s_q;
    assign lost    = '0;
`endif

    always_comb begin
        io_data = '0;
        io_sel  = 1'b0;
        if (req_in) begin
            if (addr_in == NADDR'(VEC_ADDR)) begin
                io_sel  = 1'b1;
                io_data = NUBITS'(vec_q);
            end else if (addr_in == NADDR'(STAT_ADDR)) begin
                io_sel                   = 1'b1;
                io_data[NSRC-1:0]        = pending;
                io_data[NSRC]            = (state_q == SERVICE);
                io_data[NSRC+8:NSRC+1]   = lost;
            end
        end
    end

endmodule

// File: tb/tb_itr_ctrl.sv
// Bench for itr_ctrl: phase-level reference model plus directed pins.
// Edge-mode scenarios are built only when ITR_CTRL_EDGE_EN is defined.
module tb_itr_ctrl;

    localparam int NSRC   = 4;
    localparam int NUBITS = 32;
    localparam int NADDR  = 3;
    localparam int MASK_A = 0;
    localparam int ACK_A  = 1;
    localparam int VEC_A  = 0;
    localparam int STAT_A = 1;
`ifdef ITR_CTRL_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif
    // Edges from src driven to itr visible: 2 sync (+1 pending reg) +1
    localparam int LAT = EDGE ? 4 : 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NSRC-1:0]   src = '0;
    logic              out_en = 1'b0;
    logic [NADDR-1:0]  addr_out = '0;
    logic [NUBITS-1:0] data_out = '0;
    logic              req_in = 1'b0;
    logic [NADDR-1:0]  addr_in = '0;
    logic [NUBITS-1:0] io_data;
    logic              io_sel;
    logic              itr;

    itr_ctrl #(
        .NSRC(NSRC), .NUBITS(NUBITS), .NADDR(NADDR),
        .MASK_ADDR(MASK_A), .ACK_ADDR(ACK_A),
        .VEC_ADDR(VEC_A), .STAT_ADDR(STAT_A)
    ) dut (
        .clk(clk), .rst(rst), .src(src),
        .out_en(out_en), .addr_out(addr_out), .data_out(data_out),
        .req_in(req_in), .addr_in(addr_in),
        .io_data(io_data), .io_sel(io_sel), .itr(itr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = waiting, 1 = pulsing, 2 = in service
    bit [NSRC-1:0] m_mask = '0;
    bit [NSRC-1:0] m_pend = '0;
    int            m_phase = 0;
    int            m_vec = 0;
    int            m_lost = 0;
    bit [NSRC-1:0] samp[$] = '{0, 0, 0};

    function automatic int lowest(input bit [NSRC-1:0] v);
        for (int i = 0; i < NSRC; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_step();
        bit [NSRC-1:0] ss, sd, vis, act, clr, rise, hit;
        int sum;
        if (rst) begin
            m_mask = '0; m_pend = '0; m_phase = 0; m_vec = 0; m_lost = 0;
            samp = '{0, 0, 0};
            return;
        end
        ss  = samp[1];
        sd  = samp[2];
        vis = EDGE ? m_pend : ss;
        act = vis & m_mask;
        clr = '0;
        case (m_phase)
            0: if (act != 0) begin
                m_vec = lowest(act);
                m_phase = 1;
            end
            1: m_phase = 2;
            default: if (out_en && addr_out == ACK_A) begin
                clr[m_vec] = 1'b1;
                m_phase = 0;
            end
        endcase
        if (EDGE) begin
            rise = ss & ~sd;
            hit  = rise & m_pend & ~clr;
            sum  = m_lost + $countones(hit);
            m_lost = (out_en && addr_out == STAT_A) ? 0 : (sum > 255 ? 255 : sum);
            m_pend = (m_pend & ~clr) | rise;
        end
        if (out_en && addr_out == MASK_A) m_mask = data_out[NSRC-1:0];
        samp.push_front(src);
        void'(samp.pop_back());
    endtask

    task automatic compare();
        bit [NSRC-1:0] vis;
        logic [31:0] exp_d;
        logic exp_sel;
        vis = EDGE ? m_pend : samp[1];
        chk("itr", itr, (m_phase == 1));
        exp_sel = req_in && (addr_in == VEC_A || addr_in == STAT_A);
        chk("io_sel", io_sel, exp_sel);
        if (req_in) begin
            exp_d = 0;
            if (addr_in == VEC_A) exp_d = m_vec;
            else if (addr_in == STAT_A)
                exp_d = (m_lost << (NSRC + 1)) | ((m_phase == 2) << NSRC) | vis;
            chk("io_data", io_data, exp_d);
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #2;
        compare();
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            out_en = 1'b0;
            req_in = 1'b0;
        end
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        out_en = 1'b1; req_in = 1'b0;
        addr_out = NADDR'(a); data_out = d;
        @(negedge clk);
        out_en = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        @(negedge clk);
        out_en = 1'b0; req_in = 1'b1;
        addr_in = NADDR'(a);
        #1 d = io_data;
    endtask

    task automatic drive_src(input int v);
        @(negedge clk);
        src = NSRC'(v); out_en = 1'b0; req_in = 1'b0;
    endtask

    // Count posedges until itr is seen; -1 when the budget expires
    task automatic wait_itr(input int maxc, output int n);
        n = -1;
        for (int c = 1; c <= maxc; c++) begin
            @(posedge clk);
            #1;
            if (itr) begin
                n = c;
                break;
            end
        end
    endtask

    logic [31:0] d;
    int n;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_io_sel", io_sel, 1'b0);
        chk("rst_itr", itr, 1'b0);
        rd(VEC_A, d);  chk("rst_vec", d, 0);
        chk("rst_sel_vec", io_sel, 1'b1);
        rd(STAT_A, d); chk("rst_stat", d, 0);
        rd(5, d);      chk("rst_other", d, 0);
        chk("rst_sel_other", io_sel, 1'b0);

        // Single source
        wr(MASK_A, 4'b0010);
        drive_src(4'b0010);
        wait_itr(10, n); chk("lat_single", n, LAT);
        rd(VEC_A, d);    chk("vec_single", d, 1);
        rd(STAT_A, d);   chk("stat_service", d, 32'h12);
        wr(ACK_A, 0);
        wait_itr(4, n);  chk("refire_held", n, EDGE ? -1 : 1);
        drive_src(0);
        idle(3);
        wr(ACK_A, 0);
        wait_itr(6, n);  chk("no_refire", n, -1);
        rd(STAT_A, d);   chk("stat_clear", d, 0);

        // Priority and back-to-back
        wr(MASK_A, 4'hf);
        drive_src(4'b1001);
        wait_itr(10, n); chk("lat_prio", n, LAT);
        rd(VEC_A, d);    chk("vec_prio0", d, 0);
        drive_src(4'b1000);
        idle(3);
        wr(ACK_A, 0);
        wait_itr(4, n);  chk("b2b", n, 1);
        rd(VEC_A, d);    chk("vec_prio3", d, 3);
        drive_src(0);
        idle(3);
        wr(ACK_A, 0);
        idle(3);
        rd(STAT_A, d);   chk("stat_prio_end", d, 0);

        // Masking
        wr(MASK_A, 0);
        drive_src(4'b0100);
        wait_itr(5, n);  chk("masked", n, -1);
        rd(STAT_A, d);   chk("stat_masked", d, 32'h4);
        wr(MASK_A, 4'b0100);
        wait_itr(4, n);  chk("unmask_fire", n, 1);
        drive_src(0);
        idle(3);
        wr(ACK_A, 0);
        idle(2);

`ifdef ITR_CTRL_EDGE_EN
        // Lost counter saturation
        wr(MASK_A, 0);
        repeat (300) begin
            drive_src(1);
            drive_src(0);
        end
        idle(3);
        rd(STAT_A, d);   chk("lost_sat", d, (255 << 5) | 1);
        wr(STAT_A, 0);
        rd(STAT_A, d);   chk("lost_clr", d, 1);
        wr(MASK_A, 1);
        wait_itr(4, n);  chk("lost_fire", n, 1);
        idle(1);
        wr(ACK_A, 0);
        idle(2);

        // Edge landing on the acknowledge cycle
        wr(MASK_A, 4'b0100);
        drive_src(4'b0100);
        drive_src(0);
        wait_itr(10, n); chk("lat_v2", n, LAT - 1);
        idle(2);
        @(negedge clk); src = 4'b0100;
        @(negedge clk);
        @(negedge clk); out_en = 1'b1; addr_out = ACK_A; src = 0;
        @(negedge clk); out_en = 1'b0;
        wait_itr(4, n);  chk("set_wins", n, 1);
        rd(VEC_A, d);    chk("vec_set_wins", d, 2);
        rd(STAT_A, d);   chk("stat_set_wins", d, 32'h14);
        drive_src(0);
        wr(ACK_A, 0);
        idle(2);
`endif

        // Reset during service
        wr(MASK_A, 4'b0010);
        drive_src(4'b0010);
        wait_itr(10, n); chk("lat_pre_rst", n, LAT);
        idle(2);
        rd(STAT_A, d);   chk("stat_pre_rst", d, 32'h12);
        @(negedge clk); rst = 1'b1; src = 0; req_in = 1'b0;
        @(negedge clk); rst = 1'b0;
        #1 chk("itr_post_rst", itr, 1'b0);
        rd(STAT_A, d);   chk("stat_post_rst", d, 0);
        rd(VEC_A, d);    chk("vec_post_rst", d, 0);
        drive_src(4'b0010);
        wait_itr(8, n);  chk("mask_post_rst", n, -1);
        drive_src(0);
        idle(3);

        // Randomized traffic checked every cycle by the model
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0)
                src = src ^ NSRC'(1 << $urandom_range(0, NSRC - 1));
            out_en   = ($urandom_range(0, 3) == 0);
            addr_out = NADDR'($urandom_range(0, 2));
            data_out = $urandom;
            req_in   = $urandom_range(0, 1) == 1;
            addr_in  = NADDR'($urandom_range(0, 3));
        end
        @(negedge clk); rst = 1'b0;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
